// File: rtl/mem_handshake_unit.sv
// Byte-addressed 512x8 memory behind a MOV/MFC handshake.
// Serialises big-endian byte/halfword/word accesses with a programmable wait.
module mem_handshake_unit #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 9
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        size,
  input  logic              signed_ld,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mfc,
  output logic              busy,
  output logic              align_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER,
    DONE
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WLAST =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [7:0] memory [0:DEPTH-1];

  state_t            state, state_nx;
  logic              rw_q;
  logic              sgn_q;
  logic              err_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       sh_q;
  logic [3:0]        wcnt_q;
  logic [1:0]        bcnt_q;

  logic              illegal;
  logic              last_byte;
  logic [1:0]        blast;
  logic [ADDR_W-1:0] baddr;
  logic [7:0]        rd_byte;
  logic [31:0]       asm_w;
  logic [31:0]       ext_w;
  logic [31:0]       wr_align;

  always_comb begin
    illegal = 1'b0;
    unique case (1'b1)
      size == 2'b11: illegal = 1'b1;
      size == 2'b01: illegal = address[0];
      size == 2'b10: illegal = |address[1:0];
      default:       illegal = 1'b0;
    endcase
  end

  always_comb begin
    blast    = 2'd0;
    wr_align = data_in;
    unique case (size)
      2'b00:   wr_align = {data_in[7:0], 24'h0};
      2'b01:   wr_align = {data_in[15:0], 16'h0};
      default: wr_align = data_in;
    endcase
    unique case (size_q)
      2'b00:   blast = 2'd0;
      2'b01:   blast = 2'd1;
      default: blast = 2'd3;
    endcase
  end

  // One shift register serves both directions: writes drain the
  // top byte, reads shift the fetched byte in at the bottom.
  always_comb begin
    baddr     = addr_q + ADDR_W'(bcnt_q);
    rd_byte   = memory[baddr];
    asm_w     = {sh_q[23:0], rd_byte};
    last_byte = (bcnt_q == blast);
    ext_w     = asm_w;
    unique case (size_q)
      2'b00:   ext_w = {{24{sgn_q & asm_w[7]}}, asm_w[7:0]};
      2'b01:   ext_w = {{16{sgn_q & asm_w[15]}}, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase
  end

  // Illegal requests take one decode cycle in WAIT before DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mov) begin
        if (illegal || WAIT_CYCLES != 0) state_nx = WAIT;
        else                             state_nx = XFER;
      end
      WAIT: begin
        if (err_q)                 state_nx = DONE;
        else if (wcnt_q == WLAST)  state_nx = XFER;
      end
      XFER: if (last_byte) state_nx = DONE;
      DONE: if (!mov)      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      sh_q     <= 32'h0;
      wcnt_q   <= 4'd0;
      bcnt_q   <= 2'd0;
      data_out <= 32'h0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (mov) begin
          rw_q   <= rw;
          sgn_q  <= signed_ld;
          size_q <= size;
          addr_q <= address;
          err_q  <= illegal;
          sh_q   <= wr_align;
          wcnt_q <= 4'd0;
          bcnt_q <= 2'd0;
        end
        WAIT: wcnt_q <= wcnt_q + 4'd1;
        XFER: begin
          sh_q   <= asm_w;
          bcnt_q <= bcnt_q + 2'd1;
          if (last_byte && rw_q) data_out <= ext_w;
        end
        DONE: if (!mov) err_q <= 1'b0;
      endcase
    end
  end

  always_ff @(posedge main_clk) begin
    if (state == XFER && !rw_q) memory[baddr] <= sh_q[31:24];
  end

  always_comb begin
    busy      = (state != IDLE);
    mfc       = (state == DONE);
    align_err = (state == DONE) & err_q;
  end

endmodule

// File: tb/tb_mem_handshake_unit.sv
// Randomised and directed bench for mem_handshake_unit.
// Two instances: default wait latency and zero wait latency.
module tb_mem_handshake_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mov, rw, signed_ld;
  logic [1:0]  size;
  logic [8:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        mfc, busy, align_err;

  logic        mov_b, rw_b, sgn_b;
  logic [1:0]  size_b;
  logic [8:0]  addr_b;
  logic [31:0] din_b;
  logic [31:0] dout_b;
  logic        mfc_b, busy_b, aerr_b;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mdl   [0:511];
  logic [7:0]  mdl_b [0:511];
  logic [31:0] exp_dout;

  always #5 clk = ~clk;

  mem_handshake_unit #(.WAIT_CYCLES(2), .ADDR_W(9)) dut (
    .main_clk (clk),
    .reset    (rst_n),
    .mov      (mov),
    .rw       (rw),
    .size     (size),
    .signed_ld(signed_ld),
    .address  (address),
    .data_in  (data_in),
    .data_out (data_out),
    .mfc      (mfc),
    .busy     (busy),
    .align_err(align_err)
  );

  mem_handshake_unit #(.WAIT_CYCLES(0), .ADDR_W(9)) dut0 (
    .main_clk (clk),
    .reset    (rst_n),
    .mov      (mov_b),
    .rw       (rw_b),
    .size     (size_b),
    .signed_ld(sgn_b),
    .address  (addr_b),
    .data_in  (din_b),
    .data_out (dout_b),
    .mfc      (mfc_b),
    .busy     (busy_b),
    .align_err(aerr_b)
  );

  function automatic bit is_legal(logic [1:0] sz, int a);
    if (sz == 2'b11) return 1'b0;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b0;
    if (sz == 2'b10 && (a % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nbytes(logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_read(int a, int nb, logic sg,
                                           bit use_b);
    logic [31:0] v;
    v = 32'h0;
    for (int k = 0; k < nb; k++)
      v = (v << 8) | 32'(use_b ? mdl_b[a + k] : mdl[a + k]);
    if (sg && nb < 4 && v[8 * nb - 1])
      v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  // hold < 0: drop mov right after capture
  task automatic do_op(input logic r, input logic [1:0] sz,
                       input logic sg, input int a,
                       input logic [31:0] d, input int hold,
                       input string tag);
    int  n;
    int  nb;
    bit  ok;
    int  lat;
    nb  = nbytes(sz);
    ok  = is_legal(sz, a);
    lat = ok ? (2 + nb) : 1;
    @(negedge clk);
    mov = 1'b1; rw = r; size = sz; signed_ld = sg;
    address = 9'(a); data_in = d;
    @(posedge clk); #1;
    address = 9'($urandom); data_in = $urandom;
    size = 2'($urandom); rw = 1'($urandom);
    signed_ld = 1'($urandom);
    if (hold < 0) mov = 1'b0;
    n = 0;
    while (mfc !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (ok && r) exp_dout = ref_read(a, nb, sg, 1'b0);
    if (ok && !r)
      for (int k = 0; k < nb; k++)
        mdl[a + k] = 8'((d >> (8 * (nb - 1 - k))) & 32'hFF);
    checks++;
    if (n !== lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", tag, n, lat);
    end
    checks++;
    if (align_err !== !ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s align/busy: got %b/%b expected %b/1",
               tag, align_err, busy, !ok);
    end
    checks++;
    if (data_out !== exp_dout) begin
      errors++;
      $display("FAIL %s data_out: got %h expected %h",
               tag, data_out, exp_dout);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      checks++;
      if (mfc !== 1'b1 || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s hold%0d mfc: got %b expected 1", tag, h, mfc);
      end
    end
    @(negedge clk); mov = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mfc !== 1'b0 || busy !== 1'b0 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL %s release: got mfc=%b busy=%b aerr=%b expected 0",
               tag, mfc, busy, align_err);
    end
    for (int k = 0; k < 4; k++) begin
      if (a + k < 512) begin
        checks++;
        if (dut.memory[a + k] !== mdl[a + k]) begin
          errors++;
          $display("FAIL %s mem[%0d]: got %h expected %h", tag, a + k,
                   dut.memory[a + k], mdl[a + k]);
        end
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (mfc !== 1'b0 || busy !== 1'b0 || align_err !== 1'b0 ||
        data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset: got mfc=%b busy=%b aerr=%b dout=%h expected 0",
               mfc, busy, align_err, data_out);
    end
  endtask

  task automatic test_word;
    do_op(1'b0, 2'b10, 1'b0, 8, 32'hDEADBEEF, 4, "word_wr");
    checks++;
    if ({dut.memory[8], dut.memory[9], dut.memory[10], dut.memory[11]}
        !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_bytes: got %h%h%h%h expected deadbeef",
               dut.memory[8], dut.memory[9], dut.memory[10],
               dut.memory[11]);
    end
    do_op(1'b1, 2'b10, 1'b0, 8, 32'h0, 0, "word_rd");
    checks++;
    if (data_out !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL word_rd_const: got %h expected deadbeef", data_out);
    end
  endtask

  task automatic test_byte_ext;
    mdl[5] = 8'h80;
    dut.memory[5] = 8'h80;
    do_op(1'b1, 2'b00, 1'b1, 5, 32'h0, 1, "byte_sx");
    checks++;
    if (data_out !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL byte_sx_const: got %h expected ffffff80", data_out);
    end
    do_op(1'b1, 2'b00, 1'b0, 5, 32'h0, 0, "byte_zx");
    checks++;
    if (data_out !== 32'h00000080) begin
      errors++;
      $display("FAIL byte_zx_const: got %h expected 00000080", data_out);
    end
  endtask

  task automatic test_illegal;
    do_op(1'b0, 2'b01, 1'b0, 3, 32'h0000CAFE, 2, "half_mis");
    do_op(1'b1, 2'b11, 1'b0, 12, 32'h0, 0, "size11");
    do_op(1'b1, 2'b10, 1'b1, 6, 32'h0, 1, "word_mis");
  endtask

  task automatic test_handshake;
    do_op(1'b0, 2'b01, 1'b0, 20, 32'h0000BEEF, -1, "drop_early");
    do_op(1'b1, 2'b01, 1'b1, 20, 32'h0, -1, "drop_rd");
  endtask

  task automatic test_reset_mid;
    for (int k = 16; k < 20; k++) begin
      mdl[k] = 8'h00;
      dut.memory[k] = 8'h00;
    end
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; size = 2'b10; signed_ld = 1'b0;
    address = 9'd16; data_in = 32'h11223344;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    mdl[16] = 8'h11;
    mdl[17] = 8'h22;
    exp_dout = 32'h0;
    checks++;
    if ({dut.memory[16], dut.memory[17], dut.memory[18], dut.memory[19]}
        !== 32'h11220000) begin
      errors++;
      $display("FAIL rst_mid mem: got %h%h%h%h expected 11220000",
               dut.memory[16], dut.memory[17], dut.memory[18],
               dut.memory[19]);
    end
    checks++;
    if (mfc !== 1'b0 || busy !== 1'b0 || align_err !== 1'b0 ||
        data_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_mid outs: got mfc=%b busy=%b aerr=%b dout=%h expected 0",
               mfc, busy, align_err, data_out);
    end
    mov = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 16, 32'h55667788, 0, "after_rst");
    do_op(1'b1, 2'b10, 1'b0, 16, 32'h0, 0, "after_rst_rd");
  endtask

  task automatic test_wait0;
    int n;
    int a;
    logic [31:0] exp;
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 2 : 2 * $urandom_range(0, 255);
      exp = ref_read(a, 2, 1'b0, 1'b1);
      @(negedge clk);
      mov_b = 1'b1; rw_b = 1'b1; size_b = 2'b01; sgn_b = 1'b0;
      addr_b = 9'(a); din_b = $urandom;
      @(posedge clk); #1;
      addr_b = 9'($urandom);
      n = 0;
      while (mfc_b !== 1'b1 && n < 40) begin
        @(posedge clk); #1; n++;
      end
      checks++;
      if (n !== 2 || dout_b !== exp || aerr_b !== 1'b0) begin
        errors++;
        $display("FAIL wait0_%0d: got lat=%0d dout=%h expected lat=2 dout=%h",
                 t, n, dout_b, exp);
      end
      @(negedge clk); mov_b = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mfc_b !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("FAIL wait0_rel_%0d: got mfc=%b busy=%b expected 0",
                 t, mfc_b, busy_b);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] sz;
    int a;
    int hold;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom);
      a  = $urandom_range(0, 511);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a = a & ~1;
        if (sz == 2'b10) a = a & ~3;
      end
      hold = $urandom_range(0, 4) - 1;
      do_op(1'($urandom), sz, 1'($urandom), a, $urandom, hold,
            $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    mov = 1'b0; rw = 1'b0; size = 2'b00; signed_ld = 1'b0;
    address = '0; data_in = '0;
    mov_b = 1'b0; rw_b = 1'b0; size_b = 2'b00; sgn_b = 1'b0;
    addr_b = '0; din_b = '0;
    exp_dout = 32'h0;
    for (int i = 0; i < 512; i++) begin
      mdl[i] = 8'($urandom);
      mdl_b[i] = 8'($urandom);
      dut.memory[i] = mdl[i];
      dut0.memory[i] = mdl_b[i];
    end
    mdl_b[2] = 8'hA5;
    mdl_b[3] = 8'hF3;
    dut0.memory[2] = 8'hA5;
    dut0.memory[3] = 8'hF3;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    @(negedge clk); rst_n = 1'b1;
    test_word;
    test_byte_ext;
    test_illegal;
    test_handshake;
    test_reset_mid;
    test_wait0;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
